// File: rtl/second_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : second_down_counter_pkg
// Purpose  : Shared constants, state encoding and helper function for the
//            seconds down-counter slice.
// Contents : DIGIT_W, default digit maxima, state_t, clamp_digit().
// Revision : 1.0 - initial release
// ============================================================================
package second_down_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] TENS_MAX_DEF  = 4'd5;
    localparam logic [DIGIT_W-1:0] UNITS_MAX_DEF = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // Saturate a preset digit so the counter can never hold an illegal value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] val,
        input logic [DIGIT_W-1:0] max
    );
        return (val > max) ? max : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/second_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : second_down_counter_if
// Purpose  : Groups the control, preset and status signals of the seconds
//            down-counter.
// Ports    : master - drives CE/IMPULSE/LOAD/presets/HIGHER_ZERO, reads status
//            slave  - the counter: reads controls, drives digits and status
// Revision : 1.0 - initial release
// ============================================================================
interface second_down_counter_if
    import second_down_counter_pkg::*;
;
    logic               CE;
    logic               IMPULSE;
    logic               LOAD;
    logic [DIGIT_W-1:0] LOAD_TENS;
    logic [DIGIT_W-1:0] LOAD_UNITS;
    logic               HIGHER_ZERO;
    logic [DIGIT_W-1:0] TENS;
    logic [DIGIT_W-1:0] UNITS;
    logic               BORROW;
    logic               RUNNING;
    logic               EXPIRED;

    modport master (
        output CE, IMPULSE, LOAD, LOAD_TENS, LOAD_UNITS, HIGHER_ZERO,
        input  TENS, UNITS, BORROW, RUNNING, EXPIRED
    );

    modport slave (
        input  CE, IMPULSE, LOAD, LOAD_TENS, LOAD_UNITS, HIGHER_ZERO,
        output TENS, UNITS, BORROW, RUNNING, EXPIRED
    );

endinterface
`default_nettype wire

// File: rtl/digit_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : digit_down_counter
// Purpose  : One BCD digit counting down from MAX to 0 and wrapping to MAX.
// Ports    : CLK, CLR        - clock, synchronous active-high clear
//            i_load/_val     - preset strobe and value (clamped to MAX)
//            i_dec_en        - decrement this cycle
//            o_count         - current digit
//            o_borrow        - combinational: this decrement wraps 0 -> MAX
// Revision : 1.0 - initial release
// ============================================================================
module digit_down_counter
    import second_down_counter_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = UNITS_MAX_DEF
) (
    input  wire logic               CLK,
    input  wire logic               CLR,
    input  wire logic               i_load,
    input  wire logic [DIGIT_W-1:0] i_load_val,
    input  wire logic               i_dec_en,
    output logic      [DIGIT_W-1:0] o_count,
    output logic                    o_borrow
);

    logic [DIGIT_W-1:0] count_q;
    logic [DIGIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = clamp_digit(i_load_val, MAX);
        end else if (i_dec_en) begin
            count_d = (count_q == '0) ? MAX : (count_q - DIGIT_W'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count  = count_q;
    assign o_borrow = i_dec_en && !i_load && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/second_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : second_down_counter
// Purpose  : Two-digit (tens/units) seconds down-counter with preset, run
//            control, borrow request to a minutes stage and expiry detection.
// Ports    : CLK, CLR - clock, synchronous active-high clear
//            bus      - second_down_counter_if.slave (controls, presets,
//                       TENS/UNITS digits, BORROW, RUNNING, EXPIRED)
// Revision : 1.0 - initial release
// ============================================================================
module second_down_counter
    import second_down_counter_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] TENS_MAX  = TENS_MAX_DEF,
    parameter logic [DIGIT_W-1:0] UNITS_MAX = UNITS_MAX_DEF
) (
    input  wire logic CLK,
    input  wire logic CLR,
    second_down_counter_if.slave bus
);

    state_t             state_q, state_d;
    logic               borrow_q, borrow_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;

    logic [DIGIT_W-1:0] tens_cnt;
    logic [DIGIT_W-1:0] units_cnt;
    logic               units_borrow;
    logic               tens_borrow;

    logic               at_zero;
    logic               tick;
    logic               terminal;
    logic               dec;

    // A tick only counts when running is enabled, no preset is pending and
    // the counter has not expired. IDLE accepts it too (and starts running).
    assign at_zero  = (tens_cnt == '0) && (units_cnt == '0);
    assign tick     = bus.CE && bus.IMPULSE && !bus.LOAD && (state_q != ST_EXPIRED);
    // At 00 with the minutes chain empty there is nothing to borrow from:
    // freeze the digits and expire instead of wrapping.
    assign terminal = tick && at_zero && bus.HIGHER_ZERO;
    assign dec      = tick && !terminal;

    digit_down_counter #(.MAX(UNITS_MAX)) u_units (
        .CLK        (CLK),
        .CLR        (CLR),
        .i_load     (bus.LOAD),
        .i_load_val (bus.LOAD_UNITS),
        .i_dec_en   (dec),
        .o_count    (units_cnt),
        .o_borrow   (units_borrow)
    );

    digit_down_counter #(.MAX(TENS_MAX)) u_tens (
        .CLK        (CLK),
        .CLR        (CLR),
        .i_load     (bus.LOAD),
        .i_load_val (bus.LOAD_TENS),
        .i_dec_en   (units_borrow),
        .o_count    (tens_cnt),
        .o_borrow   (tens_borrow)
    );

    always_comb begin
        state_d = state_q;
        if (bus.LOAD) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (terminal)    state_d = ST_EXPIRED;
                    else if (bus.CE) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (terminal)     state_d = ST_EXPIRED;
                    else if (!bus.CE) state_d = ST_IDLE;
                end
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
        // Both digits wrapping together means 00 -> MAX:MAX with a borrow.
        borrow_d  = tens_borrow;
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            borrow_q  <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            borrow_q  <= borrow_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign bus.TENS    = tens_cnt;
    assign bus.UNITS   = units_cnt;
    assign bus.BORROW  = borrow_q;
    assign bus.RUNNING = running_q;
    assign bus.EXPIRED = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_second_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_second_down_counter
// Purpose  : Directed self-checking bench for second_down_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_second_down_counter;

    logic clk;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    second_down_counter_if bus ();

    second_down_counter dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] t, input logic [3:0] u,
                           input logic b, input logic r, input logic e);
        chk({tag, ".tens"},    bus.TENS,          t);
        chk({tag, ".units"},   bus.UNITS,         u);
        chk({tag, ".borrow"},  {3'b0, bus.BORROW},  {3'b0, b});
        chk({tag, ".running"}, {3'b0, bus.RUNNING}, {3'b0, r});
        chk({tag, ".expired"}, {3'b0, bus.EXPIRED}, {3'b0, e});
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        bus.LOAD       = 1'b1;
        bus.LOAD_TENS  = t;
        bus.LOAD_UNITS = u;
        step();
        bus.LOAD       = 1'b0;
    endtask

    initial begin
        clr             = 1'b1;
        bus.CE          = 1'b0;
        bus.IMPULSE     = 1'b0;
        bus.LOAD        = 1'b0;
        bus.LOAD_TENS   = 4'd0;
        bus.LOAD_UNITS  = 4'd0;
        bus.HIGHER_ZERO = 1'b0;
        step();
        chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;

        // Preset 30, one tick -> 29 and running.
        do_load(4'd3, 4'd0);
        chk_all("load30", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        bus.CE = 1'b1; bus.IMPULSE = 1'b1;
        step();
        chk_all("tick29", 4'd2, 4'd9, 1'b0, 1'b1, 1'b0);
        bus.IMPULSE = 1'b0;
        step();
        chk_all("hold29", 4'd2, 4'd9, 1'b0, 1'b1, 1'b0);

        // Preset 00 with a minute available: wrap to 59 with a one-cycle borrow.
        do_load(4'd0, 4'd0);
        chk_all("load00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        bus.HIGHER_ZERO = 1'b0; bus.IMPULSE = 1'b1;
        step();
        chk_all("wrap59", 4'd5, 4'd9, 1'b1, 1'b1, 1'b0);
        bus.IMPULSE = 1'b0;
        step();
        chk_all("wrap59_after", 4'd5, 4'd9, 1'b0, 1'b1, 1'b0);

        // Preset 02 with no minutes left: 01, 00, then expire holding 00.
        bus.HIGHER_ZERO = 1'b1;
        do_load(4'd0, 4'd2);
        chk_all("load02", 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        bus.IMPULSE = 1'b1;
        step();
        chk_all("exp01", 4'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("exp00", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("expired", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("expired_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        end

        // Preset from EXPIRED (tick in the same cycle is ignored).
        do_load(4'd4, 4'd5);
        chk_all("load45_from_exp", 4'd4, 4'd5, 1'b0, 1'b0, 1'b0);

        // Oversized preset clamps to 59; paused ticks change nothing.
        bus.CE = 1'b0;
        do_load(4'd7, 4'd12);
        chk_all("clamp59", 4'd5, 4'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("paused", 4'd5, 4'd9, 1'b0, 1'b0, 1'b0);
        end

        // Count down a few ticks, then CLR together with LOAD and IMPULSE.
        bus.CE = 1'b1;
        step();
        chk_all("cnt58", 4'd5, 4'd8, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("cnt57", 4'd5, 4'd7, 1'b0, 1'b1, 1'b0);
        clr = 1'b1; bus.LOAD = 1'b1; bus.LOAD_TENS = 4'd3; bus.LOAD_UNITS = 4'd3;
        step();
        chk_all("clr_mid", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; bus.LOAD = 1'b0; bus.IMPULSE = 1'b0;

        // CE alone moves IDLE -> RUN without touching digits; CE low returns.
        step();
        chk_all("ce_run", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        bus.CE = 1'b0;
        step();
        chk_all("ce_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reach EXPIRED again and clear out of it.
        bus.CE = 1'b1;
        do_load(4'd0, 4'd1);
        bus.IMPULSE = 1'b1;
        step();
        chk_all("exp2_00", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("exp2", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        step();
        chk_all("clr_exp", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; bus.IMPULSE = 1'b0; bus.CE = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/second_down_counter.md
SECOND_DOWN_COUNTER -- requirements
Module: second_down_counter

Interface
REQ-001 SHALL have parameter TENS_MAX, default 5, meaning the largest tens digit value (seconds tens).
REQ-002 SHALL have parameter UNITS_MAX, default 9, meaning the largest units digit value.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CE  input  1  run enable; 1 = counting, 0 = paused.
REQ-006 SHALL have port IMPULSE  input  1  one-cycle 1 Hz tick pulse.
REQ-007 SHALL have port LOAD  input  1  one-cycle preset strobe.
REQ-008 SHALL have port LOAD_TENS  input  4  BCD tens preset value.
REQ-009 SHALL have port LOAD_UNITS  input  4  BCD units preset value.
REQ-010 SHALL have port HIGHER_ZERO  input  1  upstream minutes chain is 00; borrow not possible.
REQ-011 SHALL have port TENS  output  4  current tens digit.
REQ-012 SHALL have port UNITS  output  4  current units digit.
REQ-013 SHALL have port BORROW  output  1  one-cycle pulse requesting a minute decrement.
REQ-014 SHALL have port RUNNING  output  1  high in state RUN.
REQ-015 SHALL have port EXPIRED  output  1  level, high in state EXPIRED.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, EXPIRED; RUNNING = (state==RUN), EXPIRED = (state==EXPIRED), both registered.
REQ-017 Transitions SHALL be: IDLE->RUN when CE=1; RUN->IDLE when CE=0; RUN->EXPIRED on terminal tick (REQ-022); EXPIRED->IDLE only on LOAD or CLR.
REQ-018 Per-cycle priority SHALL be CLR > LOAD > IMPULSE > CE-driven transition.
REQ-019 LOAD SHALL set TENS/UNITS next cycle to preset values, each clamped to TENS_MAX/UNITS_MAX if larger, force state IDLE, and ignore IMPULSE in that cycle.
REQ-020 A decrement SHALL occur only when state is IDLE or RUN with CE=1 and IMPULSE=1 in the same cycle (the tick also moves IDLE->RUN); outputs update at that edge (latency 1 clock).
REQ-021 Decrement SHALL be: UNITS>0 -> UNITS-1; UNITS=0,TENS>0 -> TENS-1, UNITS=UNITS_MAX; 00 with HIGHER_ZERO=0 -> TENS=TENS_MAX, UNITS=UNITS_MAX, BORROW=1 for exactly that cycle.
REQ-022 At 00 with HIGHER_ZERO=1, a tick SHALL hold 00, assert no BORROW, and enter EXPIRED.
REQ-023 IMPULSE SHALL be ignored in EXPIRED and whenever CE=0; digits hold.
REQ-024 BORROW SHALL be 0 in every cycle other than REQ-021 wrap; never asserted with EXPIRED rising.
REQ-025 Digits SHALL never exceed TENS_MAX/UNITS_MAX; all arithmetic 4-bit unsigned, no modular wrap except REQ-021.

Reset
REQ-026 CLR=1 at a clock edge SHALL set TENS=0, UNITS=0, BORROW=0, state IDLE (RUNNING=0, EXPIRED=0), overriding LOAD and IMPULSE.
REQ-027 CLR mid-count or in EXPIRED SHALL behave identically to REQ-026; no asynchronous reset path.

Structure
REQ-028 A shared package SHALL hold DIGIT_W=4, default TENS_MAX/UNITS_MAX constants, and the state enum typedef (IDLE, RUN, EXPIRED).
REQ-029 SHALL instantiate sub-module digit_down_counter twice (units, tens), each with CLK, CLR, load, decrement-enable, MAX, COUNT and borrow-out; units borrow-out drives tens decrement-enable.
REQ-030 The FSM and HIGHER_ZERO terminal gating SHALL reside in second_down_counter.

Verification
REQ-031 LOAD 3/0, CE=1, 1 tick -> TENS=2, UNITS=9, BORROW=0, RUNNING=1.
REQ-032 LOAD 0/0, HIGHER_ZERO=0, CE=1, tick -> TENS=5, UNITS=9, BORROW high exactly one cycle.
REQ-033 LOAD 0/2, HIGHER_ZERO=1, CE=1, 3 ticks -> 01, 00, then EXPIRED=1 with 00; further ticks no change, BORROW never high.
REQ-034 LOAD 7/12 -> TENS=5, UNITS=9; CE=0 with 5 ticks -> digits hold, RUNNING=0.
REQ-035 Mid-count CLR asserted with LOAD and IMPULSE same cycle -> 00, IDLE, BORROW=0; then LOAD 4/5 from EXPIRED -> IDLE, 45.
